// File: rtl/regfile_if.sv
// Register-file access bundle: write strobe/index/data plus two independent read ports.
// The master (datapath) drives indices and write data; the slave (regfile) returns read data.
interface regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;

    // No handshake: a write commits on any rising edge where ctrl_writeEnable is high;
    // reads are combinational and always valid.
    modport master (
        output ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
        input  data_readRegA, data_readRegB
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
        output data_readRegA, data_readRegB
    );
endinterface

// File: rtl/regfile.sv
// 2-read/1-write register file with r0 hardwired to zero and optional same-cycle
// write-to-read forwarding. Reads are combinational; writes and reset on the rising edge.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 0
) (
    input  logic      clock,
    input  logic      ctrl_reset,
    regfile_if.slave  rf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs     [1:DEPTH-1];
    logic [DATA_WIDTH-1:0] all_regs [0:DEPTH-1];
    logic [DEPTH-1:0]      wr_en;
    logic                  hit_a;
    logic                  hit_b;

    // One-hot write decode; reset suppresses every enable and index 0 never decodes.
    always_comb begin
        wr_en = '0;
        if (rf.ctrl_writeEnable && !ctrl_reset) begin
            wr_en[rf.ctrl_writeReg] = 1'b1;
        end
        wr_en[0] = 1'b0;
    end

    assign all_regs[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        always_ff @(posedge clock) begin
            if (ctrl_reset) begin
                regs[i] <= '0;
            end else if (wr_en[i]) begin
                regs[i] <= rf.data_writeReg;
            end
        end
        assign all_regs[i] = regs[i];
    end

    // Forwarding reuses the write decode, so it is already gated by reset and r0.
    assign hit_a = (BYPASS != 0) && wr_en[rf.ctrl_readRegA];
    assign hit_b = (BYPASS != 0) && wr_en[rf.ctrl_readRegB];

    always_comb begin
        rf.data_readRegA = all_regs[rf.ctrl_readRegA];
        if (hit_a) begin
            rf.data_readRegA = rf.data_writeReg;
        end
    end

    always_comb begin
        rf.data_readRegB = all_regs[rf.ctrl_readRegB];
        if (hit_b) begin
            rf.data_readRegB = rf.data_writeReg;
        end
    end
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a stored-only instance and a forwarding instance see the
// same stimulus; readback expectations are queued and popped in order.
module tb_regfile;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clock;
    logic ctrl_reset;

    regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf0 ();
    regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf1 ();

    regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(0)) dut_nobyp (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .rf         (rf0.slave)
    );

    regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1)) dut_byp (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .rf         (rf1.slave)
    );

    assign rf1.ctrl_writeEnable = rf0.ctrl_writeEnable;
    assign rf1.ctrl_writeReg    = rf0.ctrl_writeReg;
    assign rf1.ctrl_readRegA    = rf0.ctrl_readRegA;
    assign rf1.ctrl_readRegB    = rf0.ctrl_readRegB;
    assign rf1.data_writeReg    = rf0.data_writeReg;

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_write(input logic en, input logic [AW-1:0] idx, input logic [DW-1:0] data);
        rf0.ctrl_writeEnable = en;
        rf0.ctrl_writeReg    = idx;
        rf0.data_writeReg    = data;
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        rf0.ctrl_readRegA = a;
        rf0.ctrl_readRegB = b;
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] idx, input logic [DW-1:0] data);
        drive_write(1'b1, idx, data);
        tick();
        drive_write(1'b0, '0, '0);
    endtask

    task automatic pulse_reset();
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
    endtask

    // Stimulus
    logic [DW-1:0] e;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic          alu_lt;
    logic          alu_ne;

    initial begin
        ctrl_reset = 1'b0;
        drive_write(1'b0, '0, '0);
        drive_read('0, '0);
        @(negedge clock);
        pulse_reset();

        // Everything reads zero after reset
        for (int i = 0; i < 32; i++) begin
            drive_read(AW'(i), AW'(31 - i));
            check($sformatf("rst_a[%0d]", i), rf0.data_readRegA, 32'h0);
            check($sformatf("rst_b[%0d]", 31 - i), rf0.data_readRegB, 32'h0);
            check($sformatf("rst_byp_a[%0d]", i), rf1.data_readRegA, 32'h0);
        end

        // Fill r1..r31, then read back on both ports
        for (int i = 1; i < 32; i++) begin
            write_reg(AW'(i), 32'hA5A50000 + DW'(i));
        end
        exp_q.push_back(32'h0);
        for (int i = 1; i < 32; i++) begin
            exp_q.push_back(32'hA5A50000 + DW'(i));
        end
        for (int i = 0; i < 32; i++) begin
            drive_read(AW'(i), AW'(i));
            e = exp_q.pop_front();
            check($sformatf("fill_a[%0d]", i), rf0.data_readRegA, e);
            check($sformatf("fill_b[%0d]", i), rf0.data_readRegB, e);
        end
        drive_read(5'd3, 5'd3);
        check("same_idx_a", rf0.data_readRegA, 32'hA5A50003);
        check("same_idx_b", rf0.data_readRegB, 32'hA5A50003);

        // r0 ignores writes
        write_reg(5'd0, 32'hFFFFFFFF);
        drive_read(5'd0, 5'd0);
        check("r0_a", rf0.data_readRegA, 32'h0);
        check("r0_b", rf0.data_readRegB, 32'h0);
        check("r0_byp_a", rf1.data_readRegA, 32'h0);
        drive_read(5'd1, 5'd2);
        check("r1_intact", rf0.data_readRegA, 32'hA5A50001);
        check("r2_intact", rf0.data_readRegB, 32'hA5A50002);
        drive_write(1'b1, 5'd0, 32'hFFFFFFFF);
        drive_read(5'd0, 5'd0);
        check("r0_byp_same_cycle", rf1.data_readRegA, 32'h0);
        tick();
        drive_write(1'b0, '0, '0);

        // Enable gating
        write_reg(5'd5, 32'h11010010);
        drive_write(1'b0, 5'd5, 32'hDEADBEEF);
        tick();
        drive_read(5'd5, 5'd6);
        check("we0_r5", rf0.data_readRegA, 32'h11010010);
        check("we0_r6", rf0.data_readRegB, 32'hA5A50006);
        check("we0_byp_r5", rf1.data_readRegA, 32'h11010010);

        // Collision: stored-only shows old value, forwarding shows new value
        drive_write(1'b1, 5'd5, 32'h00001100);
        drive_read(5'd5, 5'd5);
        check("coll_pre_nobyp", rf0.data_readRegA, 32'h11010010);
        check("coll_pre_byp_a", rf1.data_readRegA, 32'h00001100);
        check("coll_pre_byp_b", rf1.data_readRegB, 32'h00001100);
        tick();
        drive_write(1'b0, '0, '0);
        #1;
        check("coll_post_nobyp", rf0.data_readRegA, 32'h00001100);
        check("coll_post_byp", rf1.data_readRegA, 32'h00001100);

        // Forwarding on r7, port B on another index is unaffected
        drive_write(1'b1, 5'd7, 32'h80000001);
        drive_read(5'd7, 5'd8);
        check("byp_r7", rf1.data_readRegA, 32'h80000001);
        check("byp_other_port", rf1.data_readRegB, 32'hA5A50008);
        check("nobyp_r7", rf0.data_readRegA, 32'hA5A50007);
        tick();

        // Reset wins over a concurrent write and suppresses forwarding
        ctrl_reset = 1'b1;
        drive_write(1'b1, 5'd7, 32'h12345678);
        drive_read(5'd7, 5'd7);
        check("rst_byp_stored", rf1.data_readRegA, 32'h80000001);
        check("rst_nobyp_stored", rf0.data_readRegB, 32'h80000001);
        tick();
        ctrl_reset = 1'b0;
        drive_write(1'b0, '0, '0);
        drive_read(5'd7, 5'd5);
        check("post_rst_r7_byp", rf1.data_readRegA, 32'h0);
        check("post_rst_r7", rf0.data_readRegA, 32'h0);
        check("post_rst_r5", rf0.data_readRegB, 32'h0);

        // Operands feed a subtract (opcode 00001); result written back to r3
        write_reg(5'd1, 32'h80000001);
        write_reg(5'd2, 32'h7FFFFFFF);
        drive_read(5'd1, 5'd2);
        alu_a      = rf0.data_readRegA;
        alu_b      = rf0.data_readRegB;
        alu_result = alu_a - alu_b;
        alu_lt     = $signed(alu_a) < $signed(alu_b);
        alu_ne     = (alu_a != alu_b);
        check("alu_op_a", alu_a, 32'h80000001);
        check("alu_op_b", alu_b, 32'h7FFFFFFF);
        check("alu_isLessThan", {31'b0, alu_lt}, 32'h1);
        check("alu_isNotEqual", {31'b0, alu_ne}, 32'h1);
        write_reg(5'd3, alu_result);
        drive_read(5'd3, 5'd3);
        check("alu_wb_r3_a", rf0.data_readRegA, 32'h00000002);
        check("alu_wb_r3_b", rf1.data_readRegB, 32'h00000002);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry x 32-bit register file for the single-cycle datapath.
- Sits directly upstream of the ALU: read ports A/B drive the ALU's data_operandA/data_operandB.
- ALU data_result (or other writeback data) returns through the single write port.
- Register 0 is hardwired to zero, per ISA convention.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH = 32.
- BYPASS, 0:
  - 1: same-cycle write data is forwarded to a matching read port.
  - 0: read ports show stored contents only.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- ctrl_reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- ctrl_writeEnable  in  1  write strobe for the current cycle.
- ctrl_writeReg  in  ADDR_WIDTH  destination register index.
- ctrl_readRegA  in  ADDR_WIDTH  read port A index.
- ctrl_readRegB  in  ADDR_WIDTH  read port B index.
- data_writeReg  in  DATA_WIDTH  write data.
- data_readRegA  out  DATA_WIDTH  port A data; feeds ALU operand A.
- data_readRegB  out  DATA_WIDTH  port B data; feeds ALU operand B.

Behaviour:
- Storage: registers r1..r31 are DATA_WIDTH flops each; r0 has no storage.
- Reset:
  - A rising edge with ctrl_reset=1 clears r1..r31 to 0.
  - Reset has priority over any concurrent write; that write is discarded.
  - After reset, both read ports return 0 for every index.
  - A reset asserted mid-sequence discards all prior contents on that edge.
- Write:
  - On a rising edge with ctrl_reset=0, ctrl_writeEnable=1 and ctrl_writeReg!=0, register[ctrl_writeReg] <= data_writeReg.
  - Exactly one register changes per write.
  - ctrl_writeEnable=0 leaves all registers unchanged.
- r0 rules:
  - Writes to index 0 are silently ignored.
  - Reading index 0 always returns 0 on both ports, regardless of writes or BYPASS.
- Read:
  - Combinational, zero latency: data_readRegX = register[ctrl_readRegX] from the current index and current stored value.
  - A write becomes visible on the read ports immediately after the committing rising edge.
  - Both ports are independent and may read the same index simultaneously with identical results.
- Read/write collision (same cycle, writeReg==readRegX!=0, writeEnable=1, reset=0):
  - BYPASS=0: port shows the old value until the edge, the new value after it.
  - BYPASS=1: port shows data_writeReg combinationally in that cycle.
  - When reset=1, bypass is suppressed and the port shows the stored value.
- X handling:
  - No output may be X after the first reset.
  - Out-of-range indices cannot occur (full decode of ADDR_WIDTH).
- Implementation note: a 5-to-32 write decoder gates per-register enables; read muxes are 32:1 per port.

Test Plan:
- Reset: pulse ctrl_reset for one edge, then sweep readRegA/B over 0..31 -> all reads 32'h00000000.
- Write/read all: write r_i = 32'hA5A50000+i for i=1..31 (one per cycle), then read back on both ports -> exact values; readRegA=3, readRegB=3 both give 32'hA5A50003.
- r0 protection: write 32'hFFFFFFFF to index 0 -> both ports read 0 at index 0; r1 unchanged.
- Enable gating and collision (BYPASS=0):
  - Set r5=32'h11010010, then drive writeEnable=0 with data 32'hDEADBEEF to r5 -> r5 stays 32'h11010010.
  - Then drive writeEnable=1 with data 32'h00001100 while reading r5 -> old value before the edge, 32'h00001100 after it.
- Bypass (BYPASS=1): in the same cycle write 32'h80000001 to r7 while readRegA=7 -> data_readRegA=32'h80000001 before the edge. With reset=1 in that cycle -> shows stored value, and r7=0 after the edge.
- ALU integration: load r1=32'h80000001, r2=32'h7FFFFFFF, drive the ALU with opcode 00001 from ports A/B -> ALU isLessThan=1 and isNotEqual=1; write ALU data_result back to r3 -> read r3 = 32'h00000002.
